alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
Parametrised multi-cycle ALU, the successor to the team's single-cycle 32-bit combinational ALU. It keeps the existing 4-bit opcode set and flag outputs and generalises the datapath width. It adds iterative multiply/divide, with a valid/ready handshake on both input and output, so the CPU execute stage can stall on long operations. Result and flags are registered.

Parameters:
WIDTH, 32, datapath width in bits (power of 2, >= 8)
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  block can accept a request
op  in  4  opcode
a  in  WIDTH  operand A
b  in  WIDTH  operand B
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts result
f  out  WIDTH  result
zf  out  1  f == 0
cf  out  1  carry (ADD) / borrow (SUB), else 0
of  out  1  signed overflow (ADD/SUB), else 0
sf  out  1  f[WIDTH-1]

Behaviour:
- Opcodes: 0000 ADD, 0001 SLL, 0010 SLT (signed), 0011 SLTU, 0100 XOR, 0101 SRL, 0110 OR, 0111 AND, 1000 SUB, 1101 SRA.
- New opcodes: 1001 MUL (low WIDTH bits), 1010 MULHU (high WIDTH bits, unsigned), 1011 DIVU, 1100 REMU.
- Opcodes 1110 and 1111 produce f=0 with all flags 0 except zf=1.
- Shifts use only b[SHW-1:0]. Shifting by the full b value is no longer supported.
- ADD/SUB: {cf,f} = {0,a} +/- {0,b}.
  - ADD: of = (a msb == b msb) and (f msb != a msb).
  - SUB: of = (a msb != b msb) and (f msb != a msb).
- All other ops: cf=of=0. zf and sf are always derived from the registered f.
- FSM states:
  - IDLE: in_ready=1. On in_valid, operands are latched. Single-cycle ops go to DONE with the result registered on the same edge (latency 1). Mul/div ops go to BUSY.
  - BUSY: in_ready=0. Runs a radix-2 shift-add multiply or restoring divide, one bit per cycle. WIDTH iterations, then DONE. MUL/DIV latency is WIDTH+1 cycles from the accept edge to out_valid.
  - DONE: out_valid=1, in_ready=0. f and flags are held stable until out_ready. On out_valid & out_ready, go to IDLE.
- A back-to-back request is accepted no earlier than the cycle after the DONE handshake. Throughput is at most one op per 2 cycles.
- Divide by zero: DIVU f = all ones, REMU f = a. Completes in normal latency, no exception.
- MULHU/MUL take the same iteration count. No early termination.
- Changes on a/b/op while BUSY or DONE are ignored, because operands are latched.
- Reset (rst_n=0 at a clock edge) takes priority in every state and aborts any in-flight iteration. After reset:
  - state=IDLE, in_ready=1, out_valid=0
  - f=0, cf=of=sf=0, zf=1
  - iteration counter=0

Optional Feature:
ALU_MC_MULDIV_EN
- Defined: opcodes 1001-1100 are iterative as above, and the BUSY state and mul/div sub-module are instantiated.
- Undefined: BUSY and the sub-module are not compiled. Opcodes 1001-1100 complete in 1 cycle like 1110/1111 (f=0, zf=1). in_ready is then never low except in DONE.

Decomposition:
- Shared package alu_pkg: 4-bit opcode localparams (OP_ADD ... OP_SRA) and FSM state encoding (S_IDLE, S_BUSY, S_DONE).
- One sub-module, alu_muldiv_iter, holding:
  - the accumulator, operand shift registers and iteration counter
  - a start pulse input and a done pulse output
  - the mode input (mul-lo, mul-hi, div, rem)
- Single-cycle ops stay in the top-level alu_mc.

Test Plan:
- ADD a=0x7FFFFFFF, b=1 -> one cycle after accept: f=0x80000000, of=1, sf=1, cf=0, zf=0.
- SUB a=0, b=1 -> f=0xFFFFFFFF, cf=1, of=0. SLT a=0xFFFFFFFF, b=1 -> f=1, while SLTU -> f=0.
- SRA a=0x80000000, b=0x24 (only low 5 bits used, =4) -> f=0xF8000000. SLL with b=32 -> f=a.
- MUL a=0x10000, b=0x10000 -> out_valid exactly 33 cycles after accept: f=0; MULHU -> f=1. in_ready stays low throughout.
- DIVU a=100, b=7 -> f=14; REMU -> 2. DIVU a=5, b=0 -> 0xFFFFFFFF; REMU -> 5.
- Hold out_ready=0 for 5 cycles in DONE -> f and flags stable, in_valid ignored. Pulse rst_n=0 mid-BUSY -> next cycle IDLE, out_valid=0, zf=1. Repeat with WIDTH=8: MUL 0x10 x 0x10 -> f=0x00, MULHU=0x01, latency 9.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM states and mul/div modes for alu_mc.
// The iterative mul/div path is enabled by ALU_MC_MULDIV_EN.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SLL   = 4'b0001;
  localparam logic [3:0] OP_SLT   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_AND   = 4'b0111;
  localparam logic [3:0] OP_SUB   = 4'b1000;
  localparam logic [3:0] OP_MUL   = 4'b1001;
  localparam logic [3:0] OP_MULHU = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  localparam logic [3:0] OP_REMU  = 4'b1100;
  localparam logic [3:0] OP_SRA   = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Mode encoding equals op[1:0] - 1 for the four mul/div opcodes.
  localparam logic [1:0] MD_MULLO = 2'b00;
  localparam logic [1:0] MD_MULHI = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_REM   = 2'b11;

  function automatic logic is_muldiv(input logic [3:0] opc);
    return (opc == OP_MUL) || (opc == OP_MULHU) || (opc == OP_DIVU) || (opc == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Radix-2 shift-add multiplier / restoring divider, one bit per cycle.
// Only instantiated when ALU_MC_MULDIV_EN is defined.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] ITER_N = (SHW+1)'(WIDTH);

  logic             busy_q;
  logic [SHW:0]     cnt_q;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] md_q;
  logic [1:0]       mode_q;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH+1:0] diff_s;

  assign done_o = busy_q && (cnt_q == ITER_N);

  // One iteration step: mul adds then shifts right, div shifts left then trial-subtracts.
  always_comb begin
    sum_s     = {1'b0, acc_q[WIDTH-1:0]} + {1'b0, (mq_q[0] ? md_q : {WIDTH{1'b0}})};
    shifted_s = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
    diff_s    = {1'b0, shifted_s} - {2'b00, md_q};
    acc_d     = acc_q;
    mq_d      = mq_q;
    if ((mode_q == MD_DIV) || (mode_q == MD_REM)) begin
      if (!diff_s[WIDTH+1]) begin
        acc_d = diff_s[WIDTH:0];
        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = shifted_s;
        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_d = {1'b0, sum_s[WIDTH:1]};
      mq_d  = {sum_s[0], mq_q[WIDTH-1:1]};
    end
  end

  // Result selection: mq holds product-low / quotient, acc holds product-high / remainder.
  always_comb begin
    case (mode_q)
      MD_MULLO: result_o = mq_q;
      MD_MULHI: result_o = acc_q[WIDTH-1:0];
      MD_DIV:   result_o = mq_q;
      MD_REM:   result_o = acc_q[WIDTH-1:0];
      default:  result_o = {WIDTH{1'b0}};
    endcase
  end

  // Operand load on start, then WIDTH iterations; reset aborts an operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= {(SHW+1){1'b0}};
      acc_q  <= {(WIDTH+1){1'b0}};
      mq_q   <= {WIDTH{1'b0}};
      md_q   <= {WIDTH{1'b0}};
      mode_q <= MD_MULLO;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= {(SHW+1){1'b0}};
      acc_q  <= {(WIDTH+1){1'b0}};
      mq_q   <= a_i;
      md_q   <= b_i;
      mode_q <= mode_i;
    end else if (busy_q) begin
      if (done_o) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + {{SHW{1'b0}}, 1'b1};
        acc_q <= acc_d;
        mq_q  <= mq_d;
      end
    end else begin
      busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes and registered result/flags.
// Define ALU_MC_MULDIV_EN to build the iterative MUL/MULHU/DIVU/REMU path.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             zf,
  output logic             cf,
  output logic             of,
  output logic             sf
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             cf_q, cf_d, of_q, of_d;
  logic [WIDTH-1:0] alu_f_s;
  logic             alu_cf_s, alu_of_s;
  logic [WIDTH:0]   add_s, sub_s;
  logic [SHW-1:0]   shamt_s;
  logic             go_busy_s;

  assign shamt_s = b[SHW-1:0];
  assign add_s   = {1'b0, a} + {1'b0, b};
  assign sub_s   = {1'b0, a} - {1'b0, b};

`ifdef ALU_MC_MULDIV_EN
  logic             md_start_s, md_done_s;
  logic [WIDTH-1:0] md_result_s;
  logic [1:0]       md_mode_s;

  assign go_busy_s  = is_muldiv(op);
  assign md_start_s = (state_q == S_IDLE) && in_valid && go_busy_s;
  assign md_mode_s  = op[1:0] - 2'b01;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (md_start_s),
    .mode_i   (md_mode_s),
    .a_i      (a),
    .b_i      (b),
    .done_o   (md_done_s),
    .result_o (md_result_s)
  );
`else
  assign go_busy_s = 1'b0;
`endif

  // Single-cycle datapath; unassigned opcodes give zero with no carry/overflow.
  always_comb begin
    alu_f_s  = {WIDTH{1'b0}};
    alu_cf_s = 1'b0;
    alu_of_s = 1'b0;
    case (op)
      OP_ADD: begin
        alu_f_s  = add_s[WIDTH-1:0];
        alu_cf_s = add_s[WIDTH];
        alu_of_s = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_f_s  = sub_s[WIDTH-1:0];
        alu_cf_s = sub_s[WIDTH];
        alu_of_s = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLL:  alu_f_s = a << shamt_s;
      OP_SRL:  alu_f_s = a >> shamt_s;
      OP_SRA:  alu_f_s = $unsigned($signed(a) >>> shamt_s);
      OP_SLT:  alu_f_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_f_s = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_XOR:  alu_f_s = a ^ b;
      OP_OR:   alu_f_s = a | b;
      OP_AND:  alu_f_s = a & b;
      default: alu_f_s = {WIDTH{1'b0}};
    endcase
  end

  // Next-state and result capture for the IDLE/BUSY/DONE handshake FSM.
  always_comb begin
    state_d = state_q;
    f_d     = f_q;
    cf_d    = cf_q;
    of_d    = of_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (go_busy_s) begin
            state_d = S_BUSY;
          end else begin
            state_d = S_DONE;
            f_d     = alu_f_s;
            cf_d    = alu_cf_s;
            of_d    = alu_of_s;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
`ifdef ALU_MC_MULDIV_EN
      S_BUSY: begin
        if (md_done_s) begin
          state_d = S_DONE;
          f_d     = md_result_s;
          cf_d    = 1'b0;
          of_d    = 1'b0;
        end else begin
          state_d = S_BUSY;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      f_q     <= {WIDTH{1'b0}};
      cf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      cf_q    <= cf_d;
      of_q    <= of_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign f         = f_q;
  assign cf        = cf_q;
  assign of        = of_q;
  assign zf        = (f_q == {WIDTH{1'b0}});
  assign sf        = f_q[WIDTH-1];

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc at WIDTH=32 and WIDTH=8; flags compared as {cf,of,zf,sf}.
// Expectations follow ALU_MC_MULDIV_EN when the bundle is built with it.
module tb_alu_mc;

`ifdef ALU_MC_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, zf, cf, of, sf;
  logic [3:0]  op;
  logic [31:0] a, b, f;
  logic        v8, rdy8, ov8, ordy8, zf8, cf8, of8, sf8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, f8;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .f(f), .zf(zf), .cf(cf), .of(of), .sf(sf)
  );

  alu_mc #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .op(op8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(ordy8), .f(f8), .zf(zf8), .cf(cf8), .of(of8), .sf(sf8)
  );

  typedef struct {
    logic [31:0] f;
    logic [3:0]  fl;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic push(input logic [31:0] ef, input logic [3:0] efl, input int el);
    exp_t e;
    e.f = ef; e.fl = efl; e.lat = el;
    sb.push_back(e);
  endtask

  // Issue one op, measure edges after accept until out_valid, return result, then handshake.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] rf, output logic [3:0] rfl, output int lat, output int rdy);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
    lat = 0; rdy = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy++;
      @(posedge clk); #1;
      lat++;
    end
    rf = f; rfl = {cf, of, zf, sf};
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 4'h0; a = 32'h0; b = 32'h0;
    v8 = 1'b0; ordy8 = 1'b0; op8 = 4'h0; a8 = 8'h0; b8 = 8'h0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (f !== 32'h0) begin n_fail++; $display("FAIL reset_f got %h want 0", f); end
    n_checks++; if ({cf, of, zf, sf} !== 4'b0010) begin n_fail++; $display("FAIL reset_flags got %b want 0010", {cf, of, zf, sf}); end
    n_checks++; if ({rdy8, ov8, zf8} !== 3'b101) begin n_fail++; $display("FAIL reset_w8 got %b want 101", {rdy8, ov8, zf8}); end
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    logic [3:0]  ops [15] = '{4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0010, 4'b0011, 4'b1101, 4'b0001,
                              4'b0001, 4'b0101, 4'b0100, 4'b0110, 4'b0111, 4'b1110, 4'b1111};
    logic [31:0] xa  [15] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'h80000000, 32'h12345678, 32'h1, 32'h80000000, 32'hF0F0F0F0, 32'hF0F0F0F0,
                              32'hF0F0F0F0, 32'hDEADBEEF, 32'h5};
    logic [31:0] xb  [15] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h24, 32'h20, 32'h1F, 32'h1F,
                              32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'h1, 32'h5};
    logic [31:0] ef  [15] = '{32'h80000000, 32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h1, 32'h0, 32'hF8000000,
                              32'h12345678, 32'h80000000, 32'h1, 32'h0FF00FF0, 32'hFFF0FFF0, 32'hF000F000,
                              32'h0, 32'h0};
    logic [3:0]  efl [15] = '{4'b0101, 4'b1010, 4'b1001, 4'b0100, 4'b0000, 4'b0010, 4'b0001, 4'b0000,
                              4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0010, 4'b0010};
    logic [31:0] rf; logic [3:0] rfl; int lat, rdy; exp_t e;
    for (int i = 0; i < 15; i++) begin
      push(ef[i], efl[i], 0);
      run_op(ops[i], xa[i], xb[i], rf, rfl, lat, rdy);
      e = sb.pop_front();
      n_checks++; if (rf !== e.f) begin n_fail++; $display("FAIL alu_f[%0d] got %h want %h", i, rf, e.f); end
      n_checks++; if (rfl !== e.fl) begin n_fail++; $display("FAIL alu_flags[%0d] got %b want %b", i, rfl, e.fl); end
      n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL alu_lat[%0d] got %0d want %0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_muldiv();
    logic [3:0]  ops [8] = '{4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1011, 4'b1100, 4'b1001, 4'b1010};
    logic [31:0] xa  [8] = '{32'h10000, 32'h10000, 32'd100, 32'd100, 32'd5, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] xb  [8] = '{32'h10000, 32'h10000, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ef  [8] = '{32'h0, 32'h1, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h1, 32'hFFFFFFFE};
    logic [3:0]  efl [8] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
    logic [31:0] rf; logic [3:0] rfl; int lat, rdy; exp_t e;
    for (int i = 0; i < 8; i++) begin
      push(MD_EN ? ef[i] : 32'h0, MD_EN ? efl[i] : 4'b0010, MD_EN ? 33 : 0);
      run_op(ops[i], xa[i], xb[i], rf, rfl, lat, rdy);
      e = sb.pop_front();
      n_checks++; if (rf !== e.f) begin n_fail++; $display("FAIL md_f[%0d] got %h want %h", i, rf, e.f); end
      n_checks++; if (rfl !== e.fl) begin n_fail++; $display("FAIL md_flags[%0d] got %b want %b", i, rfl, e.fl); end
      n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL md_lat[%0d] got %0d want %0d", i, lat, e.lat); end
      n_checks++; if (rdy !== 0) begin n_fail++; $display("FAIL md_in_ready_busy[%0d] got %0d cycles want 0", i, rdy); end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    push(32'd7, 4'b0000, 0);
    @(negedge clk);
    op = 4'b0000; a = 32'd3; b = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      op = 4'b1000; a = $urandom; b = $urandom; in_valid = 1'b1;
      n_checks++; if ({out_valid, in_ready} !== 2'b10) begin n_fail++; $display("FAIL stall_hs[%0d] got %b want 10", i, {out_valid, in_ready}); end
      n_checks++; if (f !== e.f) begin n_fail++; $display("FAIL stall_f[%0d] got %h want %h", i, f, e.f); end
      n_checks++; if ({cf, of, zf, sf} !== e.fl) begin n_fail++; $display("FAIL stall_flags[%0d] got %b want %b", i, {cf, of, zf, sf}, e.fl); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL stall_release got %b want 01", {out_valid, in_ready}); end
  endtask

  task automatic test_reset_busy();
    logic [31:0] rf; logic [3:0] rfl; int lat, rdy; exp_t e;
    @(negedge clk);
    op = 4'b1001; a = 32'h10000; b = 32'h10000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstbusy_in_ready_pre got %b want 0", in_ready); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_checks++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL rstbusy_hs got %b want 10", {in_ready, out_valid}); end
    n_checks++; if (f !== 32'h0) begin n_fail++; $display("FAIL rstbusy_f got %h want 0", f); end
    n_checks++; if ({cf, of, zf, sf} !== 4'b0010) begin n_fail++; $display("FAIL rstbusy_flags got %b want 0010", {cf, of, zf, sf}); end
    push(MD_EN ? 32'd14 : 32'h0, MD_EN ? 4'b0000 : 4'b0010, MD_EN ? 33 : 0);
    run_op(4'b1011, 32'd100, 32'd7, rf, rfl, lat, rdy);
    e = sb.pop_front();
    n_checks++; if (rf !== e.f) begin n_fail++; $display("FAIL rstbusy_after_f got %h want %h", rf, e.f); end
    n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL rstbusy_after_lat got %0d want %0d", lat, e.lat); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    push(32'd2, 4'b0000, 0);
    push(32'd4, 4'b0000, 0);
    @(negedge clk);
    op = 4'b0000; a = 32'd1; b = 32'd1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    a = 32'd2; b = 32'd2;
    e = sb.pop_front();
    n_checks++; if ({out_valid, in_ready} !== 2'b10) begin n_fail++; $display("FAIL b2b_first_hs got %b want 10", {out_valid, in_ready}); end
    n_checks++; if (f !== e.f) begin n_fail++; $display("FAIL b2b_first_f got %h want %h", f, e.f); end
    @(posedge clk); #1;
    n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL b2b_gap_hs got %b want 01", {out_valid, in_ready}); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = sb.pop_front();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second_valid got %b want 1", out_valid); end
    n_checks++; if (f !== e.f) begin n_fail++; $display("FAIL b2b_second_f got %h want %h", f, e.f); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end_valid got %b want 0", out_valid); end
  endtask

  task automatic test_w8();
    logic [3:0] ops [2] = '{4'b1001, 4'b1010};
    logic [7:0] ef  [2] = '{8'h00, 8'h01};
    int lat; exp_t e;
    for (int i = 0; i < 2; i++) begin
      push(MD_EN ? {24'h0, ef[i]} : 32'h0, 4'b0000, MD_EN ? 9 : 0);
      @(negedge clk);
      op8 = ops[i]; a8 = 8'h10; b8 = 8'h10; v8 = 1'b1;
      @(posedge clk); #1;
      v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      lat = 0;
      while (!ov8 && lat < 50) begin @(posedge clk); #1; lat++; end
      e = sb.pop_front();
      n_checks++; if ({24'h0, f8} !== e.f) begin n_fail++; $display("FAIL w8_f[%0d] got %h want %h", i, f8, e.f); end
      n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL w8_lat[%0d] got %0d want %0d", i, lat, e.lat); end
      ordy8 = 1'b1;
      @(posedge clk); #1;
      ordy8 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_muldiv();
    test_stall();
    test_reset_busy();
    test_back_to_back();
    test_w8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
